rx_arbiter: RTL and testbench

- Parametrised successor to the fixed five-port receive selector.
- Arbitrates NPORTS input channels into one FIFO write port.
- Supports round-robin or fixed priority selection, and optional packet (wormhole) locking on a tail flag.
- Sits between the router input channels and the router's receive FIFO; read/write handshakes are combinational, and the grant pointer and lock state are registered.

---
 rtl/rx_arbiter.sv | 69 ++++++
 tb/tb_rx_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_arbiter.sv
// rx_arbiter: NPORTS-to-one receive FIFO arbiter with round-robin or fixed
// priority selection and optional wormhole locking released by the tail flit.
module rx_arbiter #(
  parameter int NPORTS = 5,
  parameter int SIZE = 8,
  parameter bit RR = 1'b1,
  parameter bit LOCK = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          valid_in,
  input  logic [NPORTS*SIZE-1:0]     item_in,
  input  logic [NPORTS-1:0]          tail_in,
  output logic [NPORTS-1:0]          read_out,
  input  logic                       full,
  output logic                       write,
  output logic [SIZE-1:0]            item_out,
  output logic                       tail_out,
  output logic                       locked,
  output logic [$clog2(NPORTS)-1:0]  grant_idx
);
  localparam int W = $clog2(NPORTS);
  logic [W-1:0] ptr, owner, idx;
  logic lock_q, found, act;
  function automatic logic [W-1:0] wrap(input int v);
    return W'(v % NPORTS);
  endfunction
  // Scans run from the far end so the last hit, the highest-priority one, wins.
  always_comb begin
    found = 1'b0;
    idx = '0;
    if (lock_q) begin
      found = valid_in[owner];
      idx = owner;
    end else if (RR) begin
      for (int j = NPORTS; j >= 1; j--)
        if (valid_in[wrap(int'(ptr) + j)]) begin
          found = 1'b1;
          idx = wrap(int'(ptr) + j);
        end
    end else begin
      for (int i = NPORTS - 1; i >= 0; i--)
        if (valid_in[i]) begin
          found = 1'b1;
          idx = W'(i);
        end
    end
  end
  assign act = found & reset;
  assign write = act & ~full;
  assign read_out = write ? {{(NPORTS-1){1'b0}}, 1'b1} << idx : '0;
  assign item_out = act ? item_in[idx*SIZE +: SIZE] : '0;
  assign tail_out = act & tail_in[idx];
  assign locked = lock_q;
  assign grant_idx = act ? idx : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= W'(NPORTS - 1);
      lock_q <= 1'b0;
      owner <= '0;
    end else if (write) begin
      if (RR) ptr <= idx;
      if (LOCK) begin
        lock_q <= ~tail_in[idx];
        if (!tail_in[idx]) owner <= idx;
      end
    end
  end
endmodule

// File: tb/tb_rx_arbiter.sv
// tb_rx_arbiter: four arbiter configurations on shared stimulus, checked
// against a distance-based reference model plus constant tables and sequences.
module tb_rx_arbiter;
  logic clk = 1'b0, reset = 1'b0, full = 1'b0;
  logic [4:0] valid = '0, tail = '0;
  logic [39:0] item = '0;
  logic [4:0] rd0, rd1, rd2;
  logic [2:0] rd3;
  logic wr0, wr1, wr2, wr3, to0, to1, to2, to3, lk0, lk1, lk2, lk3;
  logic [7:0] io0, io1, io2, io3;
  logic [2:0] gi0, gi1, gi2;
  logic [1:0] gi3;
  always #5 clk = ~clk;
  rx_arbiter #(.NPORTS(5), .SIZE(8), .RR(1), .LOCK(1)) u0 (.clk(clk), .reset(reset),
    .valid_in(valid), .item_in(item), .tail_in(tail), .read_out(rd0), .full(full),
    .write(wr0), .item_out(io0), .tail_out(to0), .locked(lk0), .grant_idx(gi0));
  rx_arbiter #(.NPORTS(5), .SIZE(8), .RR(1), .LOCK(0)) u1 (.clk(clk), .reset(reset),
    .valid_in(valid), .item_in(item), .tail_in(tail), .read_out(rd1), .full(full),
    .write(wr1), .item_out(io1), .tail_out(to1), .locked(lk1), .grant_idx(gi1));
  rx_arbiter #(.NPORTS(5), .SIZE(8), .RR(0), .LOCK(1)) u2 (.clk(clk), .reset(reset),
    .valid_in(valid), .item_in(item), .tail_in(tail), .read_out(rd2), .full(full),
    .write(wr2), .item_out(io2), .tail_out(to2), .locked(lk2), .grant_idx(gi2));
  rx_arbiter #(.NPORTS(3), .SIZE(8), .RR(1), .LOCK(0)) u3 (.clk(clk), .reset(reset),
    .valid_in(valid[2:0]), .item_in(item[23:0]), .tail_in(tail[2:0]), .read_out(rd3),
    .full(full), .write(wr3), .item_out(io3), .tail_out(to3), .locked(lk3), .grant_idx(gi3));

  int np[4] = '{5, 5, 5, 3};
  bit rrp[4] = '{1, 1, 0, 1};
  bit lkp[4] = '{1, 0, 1, 0};
  int m_ptr[4], m_own[4];
  bit m_lock[4];
  int vectors = 0, errs = 0;
  bit h_on = 0, t_on = 0;
  string h_name;
  logic [18:0] h_exp;
  logic [4:0] t_rr, t_fx;
  logic [1:0] t_n3;
  typedef struct {
    logic [4:0] v;
    logic f;
    logic [4:0] rr;
    logic [4:0] fx;
    logic [1:0] n3;
  } vec_t;
  vec_t tb[12];

  task automatic mreset();
    for (int k = 0; k < 4; k++) begin
      m_ptr[k] = np[k] - 1;
      m_lock[k] = 0;
      m_own[k] = 0;
    end
  endtask
  // Winner is the valid port at the smallest rotational distance past ptr (RR) or lowest index.
  function automatic int msel(int k);
    int best, bd, d;
    best = -1;
    bd = np[k];
    if (!reset) return -1;
    if (m_lock[k]) return valid[m_own[k]] ? m_own[k] : -1;
    for (int i = 0; i < np[k]; i++)
      if (valid[i]) begin
        d = rrp[k] ? (i - m_ptr[k] - 1 + 2 * np[k]) % np[k] : i;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    return best;
  endfunction
  function automatic logic [18:0] expv(int k);
    int s;
    logic [4:0] r;
    logic [7:0] it;
    s = msel(k);
    r = (s >= 0 && !full) ? 5'(1 << s) : 5'd0;
    it = (s >= 0) ? item[s*8 +: 8] : 8'd0;
    return {r, r != 0, it, s >= 0 && tail[s], m_lock[k], s >= 0 ? 3'(s) : 3'd0};
  endfunction
  function automatic logic [18:0] actv(int k);
    case (k)
      0: return {rd0, wr0, io0, to0, lk0, gi0};
      1: return {rd1, wr1, io1, to1, lk1, gi1};
      2: return {rd2, wr2, io2, to2, lk2, gi2};
      default: return {2'b00, rd3, wr3, io3, to3, lk3, 1'b0, gi3};
    endcase
  endfunction
  task automatic chk(string nm, logic [18:0] a, logic [18:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic mupdate();
    int s;
    if (!reset) mreset();
    else for (int k = 0; k < 4; k++) begin
      s = msel(k);
      if (s >= 0 && !full) begin
        if (rrp[k]) m_ptr[k] = s;
        if (lkp[k]) begin
          m_lock[k] = !tail[s];
          if (!tail[s]) m_own[k] = s;
        end
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (!reset) mreset();
    for (int k = 0; k < 4; k++) chk($sformatf("model u%0d", k), actv(k), expv(k));
    if (h_on) chk($sformatf("hand %s", h_name), actv(0), h_exp);
    if (t_on) begin
      chk("table rr read_out", {14'd0, rd1}, {14'd0, t_rr});
      chk("table fixed read_out", {14'd0, rd2}, {14'd0, t_fx});
      chk("table n3 grant_idx", {17'd0, gi3}, {17'd0, t_n3});
    end
    h_on = 0;
    t_on = 0;
    @(posedge clk);
    mupdate();
    #1;
  endtask
  task automatic hand(string n, logic [4:0] erd, logic ewr, logic [7:0] eio, logic eto,
                      logic elk, logic [2:0] egi);
    h_on = 1;
    h_name = n;
    h_exp = {erd, ewr, eio, eto, elk, egi};
    step();
  endtask

  initial begin
    logic [63:0] r64;
    tb[0] = '{5'b11111, 1'b0, 5'b00001, 5'b00001, 2'd0};
    tb[1] = '{5'b11111, 1'b0, 5'b00010, 5'b00001, 2'd1};
    tb[2] = '{5'b11111, 1'b0, 5'b00100, 5'b00001, 2'd2};
    tb[3] = '{5'b11111, 1'b0, 5'b01000, 5'b00001, 2'd0};
    tb[4] = '{5'b11111, 1'b0, 5'b10000, 5'b00001, 2'd1};
    tb[5] = '{5'b11111, 1'b0, 5'b00001, 5'b00001, 2'd2};
    tb[6] = '{5'b10110, 1'b0, 5'b00010, 5'b00010, 2'd1};
    tb[7] = '{5'b10110, 1'b0, 5'b00100, 5'b00010, 2'd2};
    tb[8] = '{5'b10110, 1'b1, 5'b00000, 5'b00000, 2'd1};
    tb[9] = '{5'b10110, 1'b0, 5'b10000, 5'b00010, 2'd1};
    tb[10] = '{5'b00000, 1'b0, 5'b00000, 5'b00000, 2'd0};
    tb[11] = '{5'b10110, 1'b0, 5'b00010, 5'b00010, 2'd2};
    mreset();
    valid = 5'b11111;
    item = 40'h1234567890;
    #1;
    hand("reset state", 5'b0, 0, 8'h00, 0, 0, 3'd0);
    hand("reset state 2", 5'b0, 0, 8'h00, 0, 0, 3'd0);
    reset = 1;
    item = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tail = 5'b11111;
    for (int i = 0; i < 12; i++) begin
      valid = tb[i].v;
      full = tb[i].f;
      t_rr = tb[i].rr;
      t_fx = tb[i].fx;
      t_n3 = tb[i].n3;
      t_on = 1;
      step();
    end
    valid = 5'b00010;
    hand("lock setup", 5'b00010, 1, 8'hA1, 1, 0, 3'd1);
    valid = 5'b10101;
    tail = 5'b10001;
    hand("lock head", 5'b00100, 1, 8'hA2, 0, 0, 3'd2);
    hand("lock body", 5'b00100, 1, 8'hA2, 0, 1, 3'd2);
    valid = 5'b10001;
    hand("lock bubble", 5'b00000, 0, 8'h00, 0, 1, 3'd0);
    valid = 5'b10101;
    tail = 5'b10101;
    hand("lock tail", 5'b00100, 1, 8'hA2, 1, 1, 3'd2);
    valid = 5'b10001;
    tail = 5'b10001;
    hand("lock next rr", 5'b10000, 1, 8'hA4, 1, 0, 3'd4);
    valid = 5'b11111;
    tail = 5'b11111;
    full = 1;
    for (int i = 0; i < 3; i++) hand("full hold", 5'b00000, 0, 8'hA0, 1, 0, 3'd0);
    full = 0;
    hand("full resume", 5'b00001, 1, 8'hA0, 1, 0, 3'd0);
    hand("full next", 5'b00010, 1, 8'hA1, 1, 0, 3'd1);
    valid = 5'b01000;
    tail = 5'b00000;
    hand("rst head", 5'b01000, 1, 8'hA3, 0, 0, 3'd3);
    hand("rst locked", 5'b01000, 1, 8'hA3, 0, 1, 3'd3);
    #2;
    reset = 0;
    #1;
    chk("async reset u0", actv(0), 19'd0);
    step();
    reset = 1;
    tail = 5'b01000;
    hand("rst regrant", 5'b01000, 1, 8'hA3, 1, 0, 3'd3);
    tail = 5'b00000;
    hand("rst tail0", 5'b01000, 1, 8'hA3, 0, 0, 3'd3);
    hand("rst relock", 5'b01000, 1, 8'hA3, 0, 1, 3'd3);
    for (int i = 0; i < 3000; i++) begin
      valid = 5'($urandom | $urandom);
      tail = 5'($urandom & $urandom);
      full = ($urandom % 4) == 0;
      r64 = {$urandom, $urandom};
      item = r64[39:0];
      reset = ($urandom % 100) != 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
